// File: rtl/measure_sequencer.sv
// Cursor-measurement sequencer: latch -> |delta| -> 7-cycle shift-add scale -> saturate -> done.
// Optional build macro AUTO_REFRESH_EN adds a free-running periodic internal start.
module measure_sequencer #(
  parameter int SAT_MAX        = 9999,
  parameter int REFRESH_CYCLES = 2500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [10:0] cursorx1,
  input  logic [10:0] cursorx2,
  input  logic [10:0] cursory1,
  input  logic [10:0] cursory2,
  input  logic [5:0]  sampleadjust1,
  input  logic [5:0]  sampleadjust2,
  input  logic [3:0]  shiftDown1,
  input  logic [3:0]  shiftDown2,
  input  logic [1:0]  waveSel,
  input  logic [2:0]  measurement,
  output logic        busy,
  output logic        done,
  output logic [13:0] num,
  output logic        overflow
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_ABS   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_SAT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [17:0] LP_SAT_ACC = 18'(SAT_MAX);
  localparam logic [13:0] LP_SAT_NUM = 14'(SAT_MAX);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_pending;
  logic [13:0] r_num;
  logic        r_ovf;
  logic        w_start;
  logic        w_valid;

  logic [10:0] r_x1, r_x2, r_y1, r_y2;
  logic        r_mode_y;
  logic [5:0]  r_sadj;
  logic [3:0]  r_sdown;
  logic [17:0] r_mcand;
  logic [6:0]  r_mplier;
  logic [17:0] r_acc;
  logic [2:0]  r_bit_cnt;
  logic [10:0] w_delta_x;
  logic [10:0] w_delta_y;

`ifdef AUTO_REFRESH_EN
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LP_REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] r_refresh_cnt;
  logic          w_auto_start;

  always_ff @(posedge clock) begin
    if (!reset_n)                            r_refresh_cnt <= '0;
    else if (r_refresh_cnt == LP_REFRESH_LAST) r_refresh_cnt <= '0;
    else                                     r_refresh_cnt <= r_refresh_cnt + 1'b1;
  end

  assign w_auto_start = (r_refresh_cnt == LP_REFRESH_LAST);
  assign w_start      = start | w_auto_start;
`else
  assign w_start = start;
`endif

  assign w_valid = (waveSel < 2'd2) && ((measurement == 3'd1) || (measurement == 3'd2));

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LATCH;
      // Invalid requests skip ABS/MUL and pass through SAT with a cleared accumulator.
      S_LATCH: w_next = w_valid ? S_ABS : S_SAT;
      S_ABS:   w_next = S_MUL;
      S_MUL:   if (r_bit_cnt == 3'd6) w_next = S_SAT;
      S_SAT:   w_next = S_DONE;
      S_DONE:  w_next = (r_pending || w_start) ? S_LATCH : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_num     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DONE)
        r_pending <= 1'b0;
      else if (r_state != S_IDLE && w_start)
        r_pending <= 1'b1;
      if (r_state == S_SAT) begin
        if (r_acc > LP_SAT_ACC) begin
          r_num <= LP_SAT_NUM;
          r_ovf <= 1'b1;
        end else begin
          r_num <= r_acc[13:0];
          r_ovf <= 1'b0;
        end
      end
    end
  end

  assign w_delta_x = (r_x1 >= r_x2) ? (r_x1 - r_x2) : (r_x2 - r_x1);
  assign w_delta_y = (r_y1 >= r_y2) ? (r_y1 - r_y2) : (r_y2 - r_y1);

  // NOTE: datapath registers carry no reset; the FSM always reloads them before they are used.
  always_ff @(posedge clock) begin
    case (r_state)
      S_LATCH: begin
        r_x1     <= cursorx1;
        r_x2     <= cursorx2;
        r_y1     <= cursory1;
        r_y2     <= cursory2;
        r_mode_y <= (measurement == 3'd2);
        r_sadj   <= (waveSel == 2'd0) ? sampleadjust1 : sampleadjust2;
        r_sdown  <= (waveSel == 2'd0) ? shiftDown1 : shiftDown2;
        r_acc    <= '0;
      end
      S_ABS: begin
        r_mcand   <= {7'd0, (r_mode_y ? w_delta_y : w_delta_x)};
        r_mplier  <= r_mode_y ? ({3'd0, r_sdown} + 7'd1) : ({1'b0, r_sadj} + 7'd1);
        r_bit_cnt <= '0;
      end
      S_MUL: begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand   <= r_mcand << 1;
        r_mplier  <= r_mplier >> 1;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign num      = r_num;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_measure_sequencer.sv
// Self-checking bench for measure_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_measure_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] cursorx1 = '0, cursorx2 = '0, cursory1 = '0, cursory2 = '0;
  logic [5:0]  sampleadjust1 = '0, sampleadjust2 = '0;
  logic [3:0]  shiftDown1 = '0, shiftDown2 = '0;
  logic [1:0]  waveSel = '0;
  logic [2:0]  measurement = '0;
  logic        busy, done, overflow;
  logic [13:0] num;

  int n_cmp = 0;
  int n_mis = 0;

  measure_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cursorx1(cursorx1), .cursorx2(cursorx2), .cursory1(cursory1), .cursory2(cursory2),
    .sampleadjust1(sampleadjust1), .sampleadjust2(sampleadjust2),
    .shiftDown1(shiftDown1), .shiftDown2(shiftDown2),
    .waveSel(waveSel), .measurement(measurement),
    .busy(busy), .done(done), .num(num), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a run starting at edge t0 samples its operands at t0+1 and lasts len edges
  // (11 valid, 3 invalid); result/done are visible after edge t0+len-1.
  function automatic void ref_result(output int res, output bit ov, output int len);
    int d, m, prod;
    if (waveSel > 2'd1 || !(measurement == 3'd1 || measurement == 3'd2)) begin
      res = 0; ov = 1'b0; len = 3;
    end else begin
      if (measurement == 3'd1) begin
        d = (int'(cursorx1) > int'(cursorx2)) ? int'(cursorx1) - int'(cursorx2)
                                              : int'(cursorx2) - int'(cursorx1);
        m = (waveSel == 2'd0 ? int'(sampleadjust1) : int'(sampleadjust2)) + 1;
      end else begin
        d = (int'(cursory1) > int'(cursory2)) ? int'(cursory1) - int'(cursory2)
                                              : int'(cursory2) - int'(cursory1);
        m = (waveSel == 2'd0 ? int'(shiftDown1) : int'(shiftDown2)) + 1;
      end
      prod = d * m;
      ov   = (prod > 9999);
      res  = ov ? 9999 : prod;
      len  = 11;
    end
  endfunction

  int cyc = 0;
  bit m_active = 0, m_pend = 0, m_busy = 0, m_done = 0, m_ovf = 0, m_run_ovf = 0;
  int m_t0 = 0, m_len = 0, m_num = 0, m_run_res = 0;
  bit chk_en = 0;

  always @(posedge clock) begin
    int p;
    if (!reset_n) begin
      m_active = 0; m_pend = 0; m_busy = 0; m_done = 0; m_num = 0; m_ovf = 0; m_len = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start) begin m_active = 1; m_t0 = cyc; m_len = 0; end
      end else begin
        p = cyc - m_t0;
        if (p == 1) ref_result(m_run_res, m_run_ovf, m_len);
        if (m_len != 0 && p == m_len) begin
          if (m_pend || start) begin m_t0 = cyc; m_len = 0; m_pend = 0; end
          else m_active = 0;
        end else if (start) begin
          m_pend = 1;
        end
      end
      m_busy = 0;
      if (m_active) begin
        p = cyc - m_t0;
        m_busy = (p == 0) || (p <= m_len - 2);
        if (m_len != 0 && p == m_len - 1) begin
          m_done = 1; m_num = m_run_res; m_ovf = m_run_ovf;
        end
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      check("model_num",  32'(num),  32'(m_num));
      check("model_ovf",  32'(overflow), 32'(m_ovf));
    end
  end

  // Called at a negedge; raises start for one edge and returns edges until done is seen.
  task automatic pulse_and_wait(output int lat);
    lat = -1;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (done) begin lat = c; break; end
    end
  endtask

  initial begin
    int lat, n_done, saw_done;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_num",  32'(num), 0);
    check("rst_ovf",  32'(overflow), 0);
    reset_n = 1'b1;
    chk_en  = 1;
    @(negedge clock);

    cursorx1 = 11'd100; cursorx2 = 11'd40; sampleadjust1 = 6'd3; waveSel = 2'd0; measurement = 3'd1;
    pulse_and_wait(lat);
    check("t1_lat", 32'(lat), 11);
    check("t1_num", 32'(num), 240);
    check("t1_ovf", 32'(overflow), 0);

    // start while DONE is showing: rerun follows immediately
    cursory1 = 11'd10; cursory2 = 11'd300; shiftDown2 = 4'd2; waveSel = 2'd1; measurement = 3'd2;
    pulse_and_wait(lat);
    check("t2_lat", 32'(lat), 11);
    check("t2_num", 32'(num), 870);
    check("t2_ovf", 32'(overflow), 0);
    @(negedge clock);

    cursorx1 = 11'd2047; cursorx2 = 11'd0; sampleadjust1 = 6'd63; waveSel = 2'd0; measurement = 3'd1;
    pulse_and_wait(lat);
    check("t3_lat", 32'(lat), 11);
    check("t3_num", 32'(num), 9999);
    check("t3_ovf", 32'(overflow), 1);
    @(negedge clock);

    measurement = 3'd0;
    pulse_and_wait(lat);
    check("t4a_lat", 32'(lat), 3);
    check("t4a_num", 32'(num), 0);
    check("t4a_ovf", 32'(overflow), 0);
    @(negedge clock);
    waveSel = 2'd3; measurement = 3'd1;
    pulse_and_wait(lat);
    check("t4b_lat", 32'(lat), 3);
    check("t4b_num", 32'(num), 0);
    @(negedge clock);

    // back-to-back: second request merged into pending, new cursor only seen by second run
    cursorx1 = 11'd100; cursorx2 = 11'd40; sampleadjust1 = 6'd3; waveSel = 2'd0; measurement = 3'd1;
    n_done = 0;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (c == 3) begin cursorx1 = 11'd500; start = 1'b1; end
      if (done) begin
        n_done++;
        if (n_done == 1) begin check("t5_first_at", 32'(c), 11); check("t5_first_num", 32'(num), 240); end
        if (n_done == 2) begin check("t5_second_at", 32'(c), 22); check("t5_second_num", 32'(num), 1840); end
      end
    end
    check("t5_done_count", 32'(n_done), 2);

    // reset during MUL aborts without done
    saw_done = 0;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (done) saw_done = 1;
      if (c == 5) reset_n = 1'b0;
      if (c == 6) begin
        check("t6_busy", 32'(busy), 0);
        check("t6_num",  32'(num), 0);
        check("t6_done", 32'(done), 0);
        reset_n = 1'b1;
      end
    end
    check("t6_no_done", 32'(saw_done), 0);
    pulse_and_wait(lat);
    check("t6_fresh_lat", 32'(lat), 11);
    check("t6_fresh_num", 32'(num), 1840);

    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      cursorx1 = 11'($urandom); cursorx2 = 11'($urandom);
      cursory1 = 11'($urandom_range(0, 700)); cursory2 = 11'($urandom_range(0, 700));
      sampleadjust1 = 6'($urandom); sampleadjust2 = 6'($urandom_range(0, 7));
      shiftDown1 = 4'($urandom); shiftDown2 = 4'($urandom);
      waveSel = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 1));
      measurement = 3'($urandom_range(0, 5) == 0 ? $urandom_range(0, 7) : $urandom_range(1, 2));
      start = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clock);
    start = 1'b0; reset_n = 1'b1;
    repeat (30) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
